// File: rtl/axi_line_refill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_line_refill_arbiter_if
// Purpose  : Requester-side line handshake plus AXI read address / read data
//            channels for the multi-channel line refill engine.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_line_refill_arbiter_if #(
  parameter int N_CH       = 2,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = LINE_WORDS * 32;

  // requester side
  logic [N_CH-1:0]    req_valid;
  logic [N_CH-1:0]    req_ready;
  logic [N_CH*32-1:0] req_addr;
  logic [N_CH-1:0]    resp_valid;
  logic [N_CH-1:0]    resp_ready;
  logic [LINE_W-1:0]  resp_line;
  logic               resp_err;

  // AXI read address channel
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;

  // AXI read data channel
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  // refill engine side
  modport master (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_line, resp_err,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  // requesters plus AXI memory side
  modport slave (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_line, resp_err,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_line_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_line_refill_arbiter
// Purpose  : Round-robin arbiter and line refill engine. Grants one requester
//            at a time, issues a single INCR burst of LINE_WORDS 32-bit beats,
//            assembles the beats into a line and returns it on the granted
//            channel together with a sticky burst-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi_line_refill_arbiter #(
  parameter int N_CH       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_line_refill_arbiter_if.master bus
);

  localparam int          LINE_W    = LINE_WORDS * 32;
  localparam int          CNT_W     = $clog2(LINE_WORDS) + 1;
  // clears the byte offset within a line
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [3:0]  LAST_CH   = 4'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         rr_q, rr_d;
  logic [3:0]         g_q, g_d;
  logic [31:0]        base_q, base_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               gnt_found;
  logic [3:0]         gnt_idx;
  logic [31:0]        gnt_addr;
  int                 cand;

  logic [N_CH-1:0]    req_ready_w;
  logic [N_CH-1:0]    resp_valid_w;
  logic               resp_ack;
  logic               arvalid_w;
  logic               rready_w;

  // Round-robin search: first requesting channel at or above rr, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      for (int j = 0; j < N_CH; j++) begin
        if (!gnt_found && (j == cand) && bus.req_valid[j]) begin
          gnt_found = 1'b1;
          gnt_idx   = 4'(j);
        end
      end
    end
  end

  // Select the granted channel's request address.
  always_comb begin
    gnt_addr = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (4'(j) == gnt_idx) gnt_addr = bus.req_addr[32*j +: 32];
    end
  end

  // Response handshake completes only on the granted channel's ready.
  always_comb begin
    resp_ack = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if ((4'(j) == g_q) && bus.resp_ready[j]) resp_ack = 1'b1;
    end
  end

  // Next-state and handshake outputs for the refill FSM.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    g_d          = g_q;
    base_d       = base_q;
    line_d       = line_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready_w  = '0;
    resp_valid_w = '0;
    arvalid_w    = 1'b0;
    rready_w     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          for (int j = 0; j < N_CH; j++) begin
            if (4'(j) == gnt_idx) req_ready_w[j] = 1'b1;
          end
          g_d     = gnt_idx;
          base_d  = gnt_addr & ADDR_MASK;
          line_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        arvalid_w = 1'b1;
        if (bus.arready) state_d = S_DATA;
      end

      S_DATA: begin
        rready_w = 1'b1;
        if (bus.rvalid) begin
          if (bus.rid == g_q) begin
            if (cnt_q < CNT_FULL) begin
              for (int k = 0; k < LINE_WORDS; k++) begin
                if (cnt_q == CNT_W'(k)) line_d[32*k +: 32] = bus.rdata;
              end
              cnt_d = cnt_q + 1'b1;
            end else begin
              // overlong burst: beat dropped
              err_d = 1'b1;
            end
            if (bus.rresp != 2'b00) err_d = 1'b1;
            if (bus.rlast) begin
              // early rlast leaves the remaining words at zero
              if (cnt_q < CNT_LAST) err_d = 1'b1;
              state_d = S_RESP;
            end
          end else begin
            // beat for another ID is consumed but flagged
            err_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        for (int j = 0; j < N_CH; j++) begin
          if (4'(j) == g_q) resp_valid_w[j] = 1'b1;
        end
        if (resp_ack) begin
          rr_d    = (g_q == LAST_CH) ? 4'd0 : g_q + 4'd1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      base_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      base_q  <= base_d;
      line_q  <= line_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_w;
  assign bus.resp_line  = line_q;
  assign bus.resp_err   = err_q;

  assign bus.arvalid    = arvalid_w;
  assign bus.araddr     = base_q;
  assign bus.arid       = g_q;
  assign bus.arlen      = 4'(LINE_WORDS - 1);
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.arlock     = 2'b00;
  assign bus.arcache    = 4'b0000;
  assign bus.arprot     = 3'b000;

  assign bus.rready     = rready_w;

endmodule
`default_nettype wire

// File: tb/tb_axi_line_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_line_refill_arbiter
// Purpose  : Directed self-checking bench for axi_line_refill_arbiter in a
//            2-channel/4-word and a 3-channel/8-word configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_line_refill_arbiter;

  localparam logic [31:0] A_ADDR0 = 32'h1000_0014;
  localparam logic [31:0] A_ADDR1 = 32'h2000_0038;
  localparam logic [31:0] A_BASE0 = 32'h1000_0010;
  localparam logic [31:0] A_BASE1 = 32'h2000_0030;

  localparam logic [31:0] B_ADDR0 = 32'h4000_0007;
  localparam logic [31:0] B_ADDR1 = 32'h5000_0021;
  localparam logic [31:0] B_ADDR2 = 32'h3000_005C;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  axi_line_refill_arbiter_if #(.N_CH(2), .LINE_WORDS(4)) ifa ();
  axi_line_refill_arbiter_if #(.N_CH(3), .LINE_WORDS(8)) ifb ();

  axi_line_refill_arbiter #(.N_CH(2), .LINE_WORDS(4)) ua (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  axi_line_refill_arbiter #(.N_CH(3), .LINE_WORDS(8)) ub (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // One line transfer on the 2-channel engine. Entered and left just after
  // a rising edge. abort_at >= 0 applies reset after that many beats.
  task automatic a_txn(input logic [1:0] reqv, input logic [1:0] after_acc, input int g,
                       input int ar_wait, input int rsp_wait, input int bad,
                       input int last, input int abort_at, input logic [31:0] dbase);
    logic [127:0] exp_line;
    logic         exp_err;
    logic [31:0]  exp_addr;
    logic [1:0]   exp_oh;
    int           w;
    bit           aborted;
    exp_addr = (g == 0) ? A_BASE0 : A_BASE1;
    exp_oh   = 2'(1 << g);
    ifa.req_addr  = {A_ADDR1, A_ADDR0};
    ifa.req_valid = reqv;
    @(negedge clk);
    chk("a_resp_idle", 256'(ifa.resp_valid), 256'(2'b00));
    w = 0;
    while (ifa.req_ready == 2'b00 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("a_grant", 256'(ifa.req_ready), 256'(exp_oh));
    @(posedge clk); #1;
    ifa.req_valid = after_acc;
    for (int c = 0; c <= ar_wait; c++) begin
      ifa.arready = (c == ar_wait);
      @(negedge clk);
      chk("a_arvalid", 256'(ifa.arvalid), 256'(1'b1));
      chk("a_araddr", 256'(ifa.araddr), 256'(exp_addr));
      chk("a_arlen", 256'(ifa.arlen), 256'(4'd3));
      chk("a_arid", 256'(ifa.arid), 256'(4'(g)));
      chk("a_rdy_busy", 256'(ifa.req_ready), 256'(2'b00));
      @(posedge clk); #1;
    end
    ifa.arready = 1'b0;
    exp_line = '0;
    aborted  = 1'b0;
    for (int b = 0; b <= last; b++) begin
      if (!aborted && b == abort_at) aborted = 1'b1;
      if (!aborted) begin
        ifa.rvalid = 1'b1;
        ifa.rid    = 4'(g);
        ifa.rdata  = dbase + 32'(b);
        ifa.rresp  = (b == bad) ? 2'b10 : 2'b00;
        ifa.rlast  = (b == last);
        exp_line[32*b +: 32] = dbase + 32'(b);
        @(negedge clk);
        if (b == 0) chk("a_rready", 256'(ifa.rready), 256'(1'b1));
        @(posedge clk); #1;
      end
    end
    ifa.rvalid = 1'b0;
    ifa.rlast  = 1'b0;
    ifa.rresp  = 2'b00;
    if (aborted) begin
      rst_n = 1'b0;
      ifa.req_valid = 2'b00;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_ready", 256'(ifa.req_ready), 256'(2'b00));
      chk("rst_resp_valid", 256'(ifa.resp_valid), 256'(2'b00));
      chk("rst_arvalid", 256'(ifa.arvalid), 256'(1'b0));
      chk("rst_rready", 256'(ifa.rready), 256'(1'b0));
      chk("rst_line", 256'(ifa.resp_line), 256'(0));
      chk("rst_err", 256'(ifa.resp_err), 256'(1'b0));
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      exp_err = (bad >= 0) || (last < 3);
      for (int c = 0; c <= rsp_wait; c++) begin
        ifa.resp_ready = (c == rsp_wait) ? exp_oh : 2'b00;
        @(negedge clk);
        chk("a_resp_valid", 256'(ifa.resp_valid), 256'(exp_oh));
        chk("a_resp_line", 256'(ifa.resp_line), 256'(exp_line));
        chk("a_resp_err", 256'(ifa.resp_err), 256'(exp_err));
        chk("a_rdy_resp", 256'(ifa.req_ready), 256'(2'b00));
        @(posedge clk); #1;
      end
      ifa.resp_ready = 2'b00;
    end
  endtask

  // One line transfer on the 3-channel, 8-word engine.
  task automatic b_txn(input logic [2:0] reqv, input int g, input logic [31:0] exp_addr,
                       input logic [31:0] dbase);
    logic [255:0] exp_line;
    logic [2:0]   exp_oh;
    int           w;
    exp_oh = 3'(1 << g);
    ifb.req_addr  = {B_ADDR2, B_ADDR1, B_ADDR0};
    ifb.req_valid = reqv;
    @(negedge clk);
    w = 0;
    while (ifb.req_ready == 3'b000 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("b_grant", 256'(ifb.req_ready), 256'(exp_oh));
    @(posedge clk); #1;
    ifb.req_valid = 3'b000;
    ifb.arready   = 1'b1;
    @(negedge clk);
    chk("b_araddr", 256'(ifb.araddr), 256'(exp_addr));
    chk("b_arlen", 256'(ifb.arlen), 256'(4'd7));
    chk("b_arid", 256'(ifb.arid), 256'(4'(g)));
    @(posedge clk); #1;
    ifb.arready = 1'b0;
    exp_line = '0;
    for (int b = 0; b < 8; b++) begin
      ifb.rvalid = 1'b1;
      ifb.rid    = 4'(g);
      ifb.rdata  = dbase + 32'(b);
      ifb.rresp  = 2'b00;
      ifb.rlast  = (b == 7);
      exp_line[32*b +: 32] = dbase + 32'(b);
      @(posedge clk); #1;
    end
    ifb.rvalid     = 1'b0;
    ifb.rlast      = 1'b0;
    ifb.resp_ready = exp_oh;
    @(negedge clk);
    chk("b_resp_valid", 256'(ifb.resp_valid), 256'(exp_oh));
    chk("b_resp_line", ifb.resp_line, exp_line);
    chk("b_resp_err", 256'(ifb.resp_err), 256'(1'b0));
    @(posedge clk); #1;
    ifb.resp_ready = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    ifa.req_valid = '0; ifa.req_addr = '0; ifa.resp_ready = '0; ifa.arready = 1'b0;
    ifa.rvalid = 1'b0; ifa.rid = '0; ifa.rdata = '0; ifa.rresp = '0; ifa.rlast = 1'b0;
    ifb.req_valid = '0; ifb.req_addr = '0; ifb.resp_ready = '0; ifb.arready = 1'b0;
    ifb.rvalid = 1'b0; ifb.rid = '0; ifb.rdata = '0; ifb.rresp = '0; ifb.rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("init_req_ready", 256'(ifa.req_ready), 256'(2'b00));
    chk("init_arvalid", 256'(ifa.arvalid), 256'(1'b0));
    chk("init_rready", 256'(ifa.rready), 256'(1'b0));
    chk("init_line", 256'(ifa.resp_line), 256'(0));
    chk("init_err", 256'(ifa.resp_err), 256'(1'b0));
    @(posedge clk); #1;

    // single request on ch0
    a_txn(2'b01, 2'b00, 0, 0, 0, -1, 3, -1, 32'h0000_00A0);
    // both channels requesting: grants alternate 1,0,1,0 (rr=1 now)
    a_txn(2'b11, 2'b11, 1, 0, 0, -1, 3, -1, 32'h0000_0100);
    a_txn(2'b11, 2'b11, 0, 0, 0, -1, 3, -1, 32'h0000_0200);
    a_txn(2'b11, 2'b11, 1, 0, 0, -1, 3, -1, 32'h0000_0300);
    a_txn(2'b11, 2'b00, 0, 0, 0, -1, 3, -1, 32'h0000_0400);
    // AR stall 5 cycles, response stall 3 cycles, ch0 pending throughout
    a_txn(2'b10, 2'b01, 1, 5, 3, -1, 3, -1, 32'h0000_0500);
    // SLVERR on beat 2
    a_txn(2'b01, 2'b00, 0, 0, 0, 1, 3, -1, 32'h0000_0600);
    // early rlast on beat 2: words 2..3 must read zero
    a_txn(2'b01, 2'b00, 0, 0, 0, -1, 1, -1, 32'h0000_0700);
    // reset during DATA after two beats (rr is 1 beforehand)
    a_txn(2'b01, 2'b00, 0, 0, 0, -1, 3, 2, 32'h0000_0800);
    // rr restarted at 0: both requesting must grant ch0
    a_txn(2'b11, 2'b00, 0, 0, 0, -1, 3, -1, 32'h0000_0900);

    // 3 channels, 8-word lines: ch2, then ch0 (rr wraps to 0), then ch2 (from rr=1)
    b_txn(3'b100, 2, 32'h3000_0040, 32'h0000_00B0);
    b_txn(3'b011, 0, 32'h4000_0000, 32'h0000_0C00);
    b_txn(3'b101, 2, 32'h3000_0040, 32'h0000_0D00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
